ps2_host_tx: RTL and testbench

PS/2 host-to-device transmitter. It sends one command byte to the keyboard, for example 0xED (set LEDs) or 0xFF (reset). It is the reverse direction of the existing scancode receive path and shares the open-drain ps2_clock/ps2_data pins with it. It sequences request-to-send, clocks out data/parity/stop on device-generated clock edges, checks the device ACK, and reports done or error.

---
 rtl/ps2_pkg.sv | 34 +++
 rtl/ps2_line_filter.sv | 61 ++++++
 rtl/ps2_host_tx.sv | 229 ++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 types: host-transmit FSM states, error codes, common keyboard commands.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INHIBIT = 3'd1,
        REQ     = 3'd2,
        START   = 3'd3,
        SEND    = 3'd4,
        ACK     = 3'd5,
        RELEASE = 3'd6,
        ERROR   = 3'd7
    } tx_state_t;

    localparam logic [1:0] ERR_NONE        = 2'd0;
    localparam logic [1:0] ERR_NO_FIRST    = 2'd1;
    localparam logic [1:0] ERR_BIT_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_NO_ACK      = 2'd3;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] CMD_ECHO    = 8'hEE;

    // Bus watchdog width; large enough for the 15 ms first-edge window at 100 MHz.
    localparam int WDOG_W = 21;

    // PS/2 frames carry odd parity: total ones over data+parity is odd.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Conditions the raw PS/2 pins: 2-FF sync on both, glitch filter on clock, clock fall detect.
// Latency: data 2 cycles; filtered clock 2 + FILTER_LEN cycles; fall pulse aligned with the filtered change.
// Backpressure: none; free-running conditioning path.
//
// Ports:
//   clk_in, reset_n        system clock, async active-low reset
//   ps2_clock_in/data_in   raw asynchronous pin levels
//   clock_filt             synced and filtered clock level
//   data_sync              synced data level
//   clock_fall             1-cycle pulse when clock_filt goes 1->0
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk_in,
    input  logic reset_n,
    input  logic ps2_clock_in,
    input  logic ps2_data_in,
    output logic clock_filt,
    output logic data_sync,
    output logic clock_fall
);

    localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic [1:0]       clk_meta;
    logic [1:0]       dat_meta;
    logic [CNT_W-1:0] diff_cnt;
    logic             filt_q;
    logic             fall_q;

    // Idle PS/2 bus is pulled high, so everything resets to 1.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            clk_meta <= 2'b11;
            dat_meta <= 2'b11;
            diff_cnt <= '0;
            filt_q   <= 1'b1;
            fall_q   <= 1'b0;
        end else begin
            clk_meta <= {clk_meta[0], ps2_clock_in};
            dat_meta <= {dat_meta[0], ps2_data_in};
            fall_q   <= 1'b0;
            // Any sample agreeing with the filtered level restarts the run.
            if (clk_meta[1] == filt_q) begin
                diff_cnt <= '0;
            end else if (diff_cnt == CNT_LAST) begin
                filt_q   <= clk_meta[1];
                diff_cnt <= '0;
                fall_q   <= filt_q;  // old level 1 means this change is a fall
            end else begin
                diff_cnt <= diff_cnt + 1'b1;
            end
        end
    end

    assign clock_filt = filt_q;
    assign data_sync  = dat_meta[1];
    assign clock_fall = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: request-to-send, 11-edge frame, ACK check, done/error.
// Latency: accept -> INHIBIT_CYCLES clock hold + 1 request cycle, then paced by device clock edges.
// Backpressure: tx_ready high only in IDLE; tx_valid while busy is ignored (no queue).
//
// Ports:
//   clk_in, reset_n                 system clock, async active-low reset
//   tx_data, tx_valid, tx_ready     command byte handshake
//   busy, done, error, err_code     status: busy frame, success pulse, failure pulse, failure cause
//   ps2_clock_in, ps2_data_in       raw open-drain pin levels
//   ps2_clock_oe, ps2_data_oe       1 = pull pin low, 0 = release
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES     = 12000,
    parameter int FIRST_EDGE_TIMEOUT = 1500000,
    parameter int BIT_TIMEOUT        = 200000,
    parameter int FILTER_LEN         = 8
) (
    input  logic       clk_in,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [1:0] err_code,
    input  logic       ps2_clock_in,
    input  logic       ps2_data_in,
    output logic       ps2_clock_oe,
    output logic       ps2_data_oe
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam logic [INH_W-1:0]  INH_LOAD = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [WDOG_W-1:0] WD_FIRST = WDOG_W'(FIRST_EDGE_TIMEOUT);
    localparam logic [WDOG_W-1:0] WD_BIT   = WDOG_W'(BIT_TIMEOUT);

    tx_state_t         state, state_nxt;
    logic [9:0]        shreg;      // {stop, parity, data[7:0]}; bit 0 is on the wire
    logic [3:0]        bit_idx;
    logic [INH_W-1:0]  inh_cnt;
    logic [WDOG_W-1:0] wdog;
    logic [1:0]        err_code_q;
    logic              done_q;
    logic              error_q;

    logic              clock_filt;
    logic              data_sync;
    logic              clock_fall;

    logic              accept;
    logic              wd_expire;
    logic              err_set;
    logic [1:0]        err_val;
    logic              done_set;
    logic              error_set;

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filter (
        .clk_in       (clk_in),
        .reset_n      (reset_n),
        .ps2_clock_in (ps2_clock_in),
        .ps2_data_in  (ps2_data_in),
        .clock_filt   (clock_filt),
        .data_sync    (data_sync),
        .clock_fall   (clock_fall)
    );

    assign busy      = (state != IDLE);
    assign tx_ready  = ~busy;
    assign accept    = tx_valid & tx_ready;
    // A fall landing on the expiry cycle wins over the timeout.
    assign wd_expire = (wdog == '0) & ~clock_fall;

    assign done      = done_q;
    assign error     = error_q;
    assign err_code  = err_code_q;

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Pin drives are decoded straight from state so an async reset releases
    // the bus in the same cycle, even mid-frame.
    always_comb begin
        state_nxt    = state;
        ps2_clock_oe = 1'b0;
        ps2_data_oe  = 1'b0;
        err_set      = 1'b0;
        err_val      = ERR_NONE;
        done_set     = 1'b0;
        error_set    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = INHIBIT;
                end
            end
            INHIBIT: begin
                ps2_clock_oe = 1'b1;
                if (inh_cnt == '0) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                ps2_clock_oe = 1'b1;
                ps2_data_oe  = 1'b1;
                state_nxt    = START;
            end
            START: begin
                ps2_data_oe = 1'b1;  // start bit held while the device wakes up
                if (clock_fall) begin
                    state_nxt = SEND;
                end else if (wd_expire) begin
                    state_nxt = ERROR;
                    err_set   = 1'b1;
                    err_val   = ERR_NO_FIRST;
                end
            end
            SEND: begin
                ps2_data_oe = ~shreg[0];
                if (clock_fall) begin
                    // Fall 10 puts the stop bit out; the device ACKs on fall 11.
                    if (bit_idx == 4'd8) begin
                        state_nxt = ACK;
                    end
                end else if (wd_expire) begin
                    state_nxt = ERROR;
                    err_set   = 1'b1;
                    err_val   = ERR_BIT_TIMEOUT;
                end
            end
            ACK: begin
                if (clock_fall) begin
                    if (!data_sync) begin
                        state_nxt = RELEASE;
                    end else begin
                        state_nxt = ERROR;
                        err_set   = 1'b1;
                        err_val   = ERR_NO_ACK;
                    end
                end else if (wd_expire) begin
                    state_nxt = ERROR;
                    err_set   = 1'b1;
                    err_val   = ERR_BIT_TIMEOUT;
                end
            end
            RELEASE: begin
                if (clock_filt && data_sync) begin
                    state_nxt = IDLE;
                    done_set  = 1'b1;
                end else if (wd_expire) begin
                    state_nxt = ERROR;
                    err_set   = 1'b1;
                    err_val   = ERR_BIT_TIMEOUT;
                end
            end
            ERROR: begin
                state_nxt = IDLE;
                error_set = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            shreg      <= '1;
            bit_idx    <= '0;
            inh_cnt    <= '0;
            wdog       <= '0;
            err_code_q <= ERR_NONE;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            done_q  <= done_set;
            error_q <= error_set;

            if (accept) begin
                shreg      <= {1'b1, odd_parity(tx_data), tx_data};
                err_code_q <= ERR_NONE;
                inh_cnt    <= INH_LOAD;
            end

            if (err_set) begin
                err_code_q <= err_val;
            end

            case (state)
                INHIBIT: begin
                    if (inh_cnt != '0) begin
                        inh_cnt <= inh_cnt - 1'b1;
                    end
                end
                REQ: begin
                    wdog <= WD_FIRST;
                end
                START, SEND, ACK, RELEASE: begin
                    if (clock_fall) begin
                        wdog <= WD_BIT;
                    end else if (wdog != '0) begin
                        wdog <= wdog - 1'b1;
                    end
                end
                default: begin
                end
            endcase

            // Data bit 0 is already at shreg[0] when the first fall arrives.
            if (clock_fall) begin
                if (state == START) begin
                    bit_idx <= '0;
                end else if (state == SEND) begin
                    shreg   <= {1'b1, shreg[9:1]};
                    bit_idx <= bit_idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

    logic       clk_in = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, busy, done, error;
    logic [1:0] err_code;
    logic       ps2_clock_in, ps2_data_in;
    logic       ps2_clock_oe, ps2_data_oe;

    // Device side of the open-drain bus: 1 = released.
    logic dev_clk = 1'b1;
    logic dev_dat = 1'b1;
    logic glitch  = 1'b0;

    assign ps2_clock_in = ~ps2_clock_oe & dev_clk & ~glitch;
    assign ps2_data_in  = ~ps2_data_oe & dev_dat;

    ps2_host_tx #(
        .INHIBIT_CYCLES     (100),
        .FIRST_EDGE_TIMEOUT (5000),
        .BIT_TIMEOUT        (2000),
        .FILTER_LEN         (2)
    ) dut (
        .clk_in       (clk_in),
        .reset_n      (reset_n),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .err_code     (err_code),
        .ps2_clock_in (ps2_clock_in),
        .ps2_data_in  (ps2_data_in),
        .ps2_clock_oe (ps2_clock_oe),
        .ps2_data_oe  (ps2_data_oe)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bus monitor, sampled on the falling clock edge.
    int         cyc = 0;
    int         inh_run = 0;
    int         last_inh = 0;
    int         reqs = 0;
    int         req_cyc = 0;
    int         done_cnt = 0;
    int         err_cnt = 0;
    int         err_cyc = 0;
    logic [1:0] err_code_at = 2'd0;
    logic [1:0] oe_at_err = 2'd0;
    int         last_fall = 0;

    always @(negedge clk_in) begin
        cyc = cyc + 1;
        if (ps2_clock_oe && !ps2_data_oe) begin
            inh_run = inh_run + 1;
        end else if (ps2_clock_oe && ps2_data_oe) begin
            if (inh_run != 0) begin
                last_inh = inh_run;
                reqs     = reqs + 1;
                req_cyc  = cyc;
            end
            inh_run = 0;
        end else begin
            inh_run = 0;
        end
        if (done) done_cnt = done_cnt + 1;
        if (error) begin
            err_cnt     = err_cnt + 1;
            err_cyc     = cyc;
            err_code_at = err_code;
            oe_at_err   = {ps2_clock_oe, ps2_data_oe};
        end
    end

    task automatic send(input logic [7:0] d);
        @(posedge clk_in);
        #1;
        tx_data  = d;
        tx_valid = 1'b1;
        @(posedge clk_in);
        #1;
        tx_valid = 1'b0;
    endtask

    // Device model: 40-cycle half period. Samples the start bit before the first
    // fall, then one bit per rising edge; optionally ACKs on fall 11.
    task automatic dev_frame(input int nfalls, input bit ack_ok, input int glitch_after,
                             output logic [10:0] bits);
        int t;
        bits = '0;
        t = 0;
        while (!ps2_clock_oe && t < 2000) begin @(negedge clk_in); t++; end
        if (t >= 2000) check("dev_inhibit_seen", 32'(ps2_clock_oe), 32'd1);
        t = 0;
        while (ps2_clock_oe && t < 2000) begin @(negedge clk_in); t++; end
        if (t >= 2000) check("dev_release_seen", 32'(ps2_clock_oe), 32'd0);
        repeat (40) @(negedge clk_in);
        bits[0] = ps2_data_in;
        for (int k = 1; k <= nfalls && k <= 10; k++) begin
            dev_clk   = 1'b0;
            last_fall = cyc;
            repeat (40) @(negedge clk_in);
            dev_clk = 1'b1;
            @(negedge clk_in);
            bits[k] = ps2_data_in;
            if (k == glitch_after) begin
                repeat (10) @(negedge clk_in);
                glitch = 1'b1;
                @(negedge clk_in);
                glitch = 1'b0;
                repeat (28) @(negedge clk_in);
            end else begin
                repeat (39) @(negedge clk_in);
            end
        end
        if (nfalls >= 11) begin
            if (ack_ok) dev_dat = 1'b0;
            repeat (20) @(negedge clk_in);
            dev_clk = 1'b0;
            repeat (40) @(negedge clk_in);
            dev_clk = 1'b1;
            repeat (20) @(negedge clk_in);
            dev_dat = 1'b1;
        end
    endtask

    task automatic wait_end(input int d0, input int e0, input string tag);
        int t;
        t = 0;
        while (done_cnt == d0 && err_cnt == e0 && t < 10000) begin
            @(negedge clk_in);
            t++;
        end
        if (t >= 10000) check({tag, "_end_timeout"}, 32'(busy), 32'd0);
        repeat (3) @(negedge clk_in);
    endtask

    task automatic run_frame(input logic [7:0] d, input logic par, input string tag);
        int d0, e0;
        logic [10:0] bits;
        d0 = done_cnt;
        e0 = err_cnt;
        send(d);
        dev_frame(11, 1'b1, 0, bits);
        wait_end(d0, e0, tag);
        check({tag, "_bits"}, 32'(bits), 32'({1'b1, par, d, 1'b0}));
        check({tag, "_done"}, 32'(done_cnt - d0), 32'd1);
        check({tag, "_noerr"}, 32'(err_cnt - e0), 32'd0);
        check({tag, "_errcode"}, 32'(err_code), 32'd0);
    endtask

    logic [7:0] t2_dat [3] = '{8'h01, 8'hFF, 8'h00};
    logic       t2_par [3] = '{1'b0, 1'b1, 1'b1};

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int d0, e0, r0, diff;
        logic [10:0] bits;

        // Reset state
        #1;
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_oe", 32'({ps2_clock_oe, ps2_data_oe}), 32'd0);
        check("rst_pulses", 32'({done, error}), 32'd0);
        check("rst_err_code", 32'(err_code), 32'd0);
        repeat (5) @(negedge clk_in);
        reset_n = 1'b1;
        repeat (5) @(negedge clk_in);

        // 1: 0xED, full handshake
        d0 = done_cnt;
        e0 = err_cnt;
        send(8'hED);
        @(negedge clk_in);
        check("t1_busy_after_accept", 32'(busy), 32'd1);
        dev_frame(11, 1'b1, 0, bits);
        wait_end(d0, e0, "t1");
        check("t1_inhibit_len", 32'(last_inh), 32'd100);
        check("t1_bits", 32'(bits), 32'({1'b1, 1'b1, 8'hED, 1'b0}));
        check("t1_done", 32'(done_cnt - d0), 32'd1);
        check("t1_err_code", 32'(err_code), 32'd0);
        check("t1_busy_drop", 32'(busy), 32'd0);

        // 2: parity corners
        for (int i = 0; i < 3; i++) run_frame(t2_dat[i], t2_par[i], $sformatf("t2_%0d", i));

        // 3: device never clocks
        e0 = err_cnt;
        send(8'hFF);
        dev_frame(0, 1'b1, 0, bits);
        wait_end(done_cnt, e0, "t3");
        diff = err_cyc - req_cyc;
        check("t3_error", 32'(err_cnt - e0), 32'd1);
        check("t3_err_code", 32'(err_code_at), 32'd1);
        check("t3_time_window", 32'(diff >= 5000 && diff <= 5005), 32'd1);
        check("t3_oe_released", 32'(oe_at_err), 32'd0);

        // 4a: device stalls after fall 5
        e0 = err_cnt;
        send(8'hED);
        dev_frame(5, 1'b1, 0, bits);
        wait_end(done_cnt, e0, "t4a");
        diff = err_cyc - last_fall;
        check("t4a_err_code", 32'(err_code_at), 32'd2);
        check("t4a_time_window", 32'(diff >= 2000 && diff <= 2020), 32'd1);

        // 4b: no ACK
        e0 = err_cnt;
        send(8'hED);
        dev_frame(11, 1'b0, 0, bits);
        wait_end(done_cnt, e0, "t4b");
        check("t4b_err_code", 32'(err_code_at), 32'd3);
        check("t4b_err_code_held", 32'(err_code), 32'd3);

        // 5: reset while bit 4 (0 for 0xED) is on the wire
        send(8'hED);
        dev_frame(5, 1'b1, 0, bits);
        check("t5_bit4_driven", 32'({ps2_clock_oe, ps2_data_oe}), 32'b01);
        @(posedge clk_in);
        #1;
        reset_n = 1'b0;
        #1;
        check("t5_oe_async", 32'({ps2_clock_oe, ps2_data_oe}), 32'd0);
        check("t5_tx_ready", 32'(tx_ready), 32'd1);
        repeat (3) @(negedge clk_in);
        reset_n = 1'b1;
        repeat (5) @(negedge clk_in);
        run_frame(8'hEE, 1'b1, "t5_echo");

        // 6: tx_valid held with 0x55 while busy, plus a clock glitch
        r0 = reqs;
        d0 = done_cnt;
        e0 = err_cnt;
        send(8'h12);
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        fork
            dev_frame(11, 1'b1, 3, bits);
            begin
                repeat (300) @(negedge clk_in);
                tx_valid = 1'b0;
            end
        join
        wait_end(d0, e0, "t6");
        repeat (300) @(negedge clk_in);
        check("t6_bits", 32'(bits), 32'({1'b1, 1'b1, 8'h12, 1'b0}));
        check("t6_one_frame", 32'(reqs - r0), 32'd1);
        check("t6_done", 32'(done_cnt - d0), 32'd1);
        check("t6_idle", 32'(tx_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
